// File: rtl/rffe_slave_responder_if.sv
// rtl/rffe_slave_responder_if.sv - RFFE two-wire bus bundle (SCLK in, SDA in/out/enable)
interface rffe_slave_responder_if;
  logic sclk_i;
  logic sda_i;
  logic sda_o;
  logic sda_oe;

  modport master (
    output sclk_i,
    output sda_i,
    input  sda_o,
    input  sda_oe
  );

  modport slave (
    input  sclk_i,
    input  sda_i,
    output sda_o,
    output sda_oe
  );
endinterface

// File: rtl/rffe_slave_responder.sv
// rtl/rffe_slave_responder.sv - RFFE slave: SSC detect, command decode, 32x8 register file, read-back drive
module rffe_slave_responder #(
  parameter logic [3:0] USID        = 4'h7,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rffe_slave_responder_if.slave bus,
  output logic                 reg_wr,
  output logic [4:0]           reg_waddr,
  output logic [7:0]           reg_wdata,
  output logic                 parity_err,
  input  logic [4:0]           dbg_addr,
  output logic [7:0]           dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_BPARK_W,
    S_RPARK,
    S_RDATA,
    S_BPARK_R,
    S_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic sclk_hist_q, sclk_hist_d;
  logic sda_hist_q, sda_hist_d;
  logic ssc_arm_q, ssc_arm_d;

  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [12:0] shift_q, shift_d;
  logic [4:0]  addr_q, addr_d;
  logic        sda_o_q, sda_o_d;
  logic        sda_oe_q, sda_oe_d;
  logic        reg_wr_q, reg_wr_d;
  logic [4:0]  reg_waddr_q, reg_waddr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        parity_err_q, parity_err_d;
  logic [7:0]  regs_q [32];
  logic [7:0]  regs_d [32];

  logic sclk_s, sda_s;
  logic sclk_rise, sclk_fall, sda_rise, sda_fall, ssc;
  logic [12:0] cmd_frame;
  logic [8:0]  dat_frame;
  logic [3:0]  cmd_sa;
  logic [7:0]  cmd_c;
  logic        cmd_is_wr, cmd_sa_ok;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign sda_rise  = sda_s & ~sda_hist_q;
  assign sda_fall  = ~sda_s & sda_hist_q;
  // An SDA fall only counts as SSC if it follows an SDA rise with SCLK low the whole time.
  assign ssc       = ssc_arm_q & sda_fall & ~sclk_s;

  assign cmd_frame = {shift_q[11:0], sda_s};
  assign dat_frame = {shift_q[7:0], sda_s};
  assign cmd_sa    = cmd_frame[12:9];
  assign cmd_c     = cmd_frame[8:1];
  assign cmd_is_wr = cmd_c[7] | (cmd_c[7:5] == 3'b010);
  assign cmd_sa_ok = (cmd_sa == USID) | ((cmd_sa == 4'd0) & cmd_is_wr);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk_i};
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
    sclk_hist_d = sclk_s;
    sda_hist_d  = sda_s;
    ssc_arm_d   = ssc_arm_q;
    if (sclk_s) begin
      ssc_arm_d = 1'b0;
    end else if (sda_rise) begin
      ssc_arm_d = 1'b1;
    end else if (sda_fall) begin
      ssc_arm_d = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    addr_d       = addr_q;
    sda_o_d      = sda_o_q;
    sda_oe_d     = sda_oe_q;
    reg_wr_d     = 1'b0;
    reg_waddr_d  = reg_waddr_q;
    reg_wdata_d  = reg_wdata_q;
    parity_err_d = 1'b0;

    case (state_q)
      S_CMD: begin
        if (sclk_fall) begin
          shift_d   = cmd_frame;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd12) begin
            bit_cnt_d = 4'd0;
            if (^cmd_frame != 1'b1) begin
              parity_err_d = 1'b1;
              state_d      = S_IGNORE;
            end else if (!cmd_sa_ok) begin
              state_d = S_IGNORE;
            end else if (cmd_c[7]) begin
              reg_wr_d    = 1'b1;
              reg_waddr_d = 5'd0;
              reg_wdata_d = {1'b0, cmd_c[6:0]};
              state_d     = S_BPARK_W;
            end else if (cmd_c[7:5] == 3'b010) begin
              addr_d  = cmd_c[4:0];
              state_d = S_WDATA;
            end else if (cmd_c[7:5] == 3'b011) begin
              addr_d  = cmd_c[4:0];
              state_d = S_RPARK;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
      end

      S_WDATA: begin
        if (sclk_fall) begin
          shift_d   = {shift_q[11:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            state_d   = S_BPARK_W;
            if (^dat_frame == 1'b1) begin
              reg_wr_d    = 1'b1;
              reg_waddr_d = addr_q;
              reg_wdata_d = dat_frame[8:1];
            end else begin
              parity_err_d = 1'b1;
            end
          end
        end
      end

      S_BPARK_W: begin
        if (sclk_fall) begin
          state_d = S_IDLE;
        end
      end

      S_RPARK: begin
        // The read frame sits in the top 9 bits so RDATA can shift out of bit 12.
        if (sclk_fall) begin
          shift_d   = {regs_q[addr_q], ~^regs_q[addr_q], 4'b0000};
          bit_cnt_d = 4'd0;
          state_d   = S_RDATA;
        end
      end

      S_RDATA: begin
        if (sclk_rise) begin
          sda_oe_d  = 1'b1;
          sda_o_d   = shift_q[12];
          shift_d   = {shift_q[11:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) begin
            state_d = S_BPARK_R;
          end
        end
      end

      S_BPARK_R: begin
        // bit_cnt 9 marks "waiting for park rise", 10 marks "park bit driven".
        if (sclk_rise) begin
          sda_o_d   = 1'b0;
          bit_cnt_d = 4'd10;
        end else if (sclk_fall && (bit_cnt_q == 4'd10)) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
          state_d   = S_IDLE;
        end
      end

      default: begin
      end
    endcase

    if (ssc) begin
      state_d      = S_CMD;
      bit_cnt_d    = 4'd0;
      shift_d      = 13'd0;
      sda_o_d      = 1'b0;
      sda_oe_d     = 1'b0;
      reg_wr_d     = 1'b0;
      parity_err_d = 1'b0;
    end
  end

  // Register file updates one cycle after the reg_wr pulse, from the held waddr/wdata.
  always_comb begin
    regs_d = regs_q;
    if (reg_wr_q) begin
      regs_d[reg_waddr_q] = reg_wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q  <= '0;
      sda_sync_q   <= '0;
      sclk_hist_q  <= 1'b0;
      sda_hist_q   <= 1'b0;
      ssc_arm_q    <= 1'b0;
      state_q      <= S_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 13'd0;
      addr_q       <= 5'd0;
      sda_o_q      <= 1'b0;
      sda_oe_q     <= 1'b0;
      reg_wr_q     <= 1'b0;
      reg_waddr_q  <= 5'd0;
      reg_wdata_q  <= 8'd0;
      parity_err_q <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 8'd0;
      end
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      sda_sync_q   <= sda_sync_d;
      sclk_hist_q  <= sclk_hist_d;
      sda_hist_q   <= sda_hist_d;
      ssc_arm_q    <= ssc_arm_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      sda_o_q      <= sda_o_d;
      sda_oe_q     <= sda_oe_d;
      reg_wr_q     <= reg_wr_d;
      reg_waddr_q  <= reg_waddr_d;
      reg_wdata_q  <= reg_wdata_d;
      parity_err_q <= parity_err_d;
      regs_q       <= regs_d;
    end
  end

  assign bus.sda_o  = sda_o_q;
  assign bus.sda_oe = sda_oe_q;
  assign reg_wr     = reg_wr_q;
  assign reg_waddr  = reg_waddr_q;
  assign reg_wdata  = reg_wdata_q;
  assign parity_err = parity_err_q;
  assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_rffe_slave_responder.sv
// tb/tb_rffe_slave_responder.sv - scoreboard bench for rffe_slave_responder
module tb_rffe_slave_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_sda = 1'b0;
  logic reg_wr, parity_err;
  logic [4:0] reg_waddr;
  logic [7:0] reg_wdata;
  logic [4:0] dbg_addr = 5'd0;
  logic [7:0] dbg_data;

  always #5 clk = ~clk;

  rffe_slave_responder_if bus_if ();
  assign bus_if.sda_i = bus_if.sda_oe ? bus_if.sda_o : m_sda;

  rffe_slave_responder #(.USID(4'h7), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .reg_wr     (reg_wr),
    .reg_waddr  (reg_waddr),
    .reg_wdata  (reg_wdata),
    .parity_err (parity_err),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  int checks = 0;
  int errors = 0;
  int perr_seen = 0;
  int perr_exp = 0;
  bit oe_seen = 1'b0;
  logic [12:0] wr_exp_q [$];
  logic        rd_exp_q [$];
  logic [7:0]  mem [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr) begin
        if (wr_exp_q.size() == 0)
          check("wr_unexpected", 32'({reg_wr, reg_waddr, reg_wdata}), 32'd0);
        else
          check("wr_event", 32'({reg_waddr, reg_wdata}), 32'(wr_exp_q.pop_front()));
      end
      if (parity_err) perr_seen++;
      if (bus_if.sda_oe) oe_seen = 1'b1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bit_clk(input logic b);
    bus_if.sclk_i = 1'b1;
    wait_clk(4);
    m_sda = b;
    wait_clk(6);
    bus_if.sclk_i = 1'b0;
    wait_clk(10);
  endtask

  task automatic ssc();
    m_sda = 1'b0;
    wait_clk(6);
    m_sda = 1'b1;
    wait_clk(10);
    m_sda = 1'b0;
    wait_clk(10);
  endtask

  task automatic send_cmd(input logic [3:0] sa, input logic [7:0] c, input logic bad);
    logic [11:0] f;
    f = {sa, c};
    ssc();
    for (int i = 11; i >= 0; i--) bit_clk(f[i]);
    bit_clk(~^f ^ bad);
  endtask

  task automatic do_write(input logic [3:0] sa, input logic [4:0] a, input logic [7:0] d,
                          input logic bad_cmd, input logic bad_dat);
    logic hit;
    hit = (sa == 4'h7) || (sa == 4'h0);
    if (bad_cmd) perr_exp++;
    else if (hit && bad_dat) perr_exp++;
    else if (hit) begin
      wr_exp_q.push_back({a, d});
      mem[a] = d;
    end
    send_cmd(sa, {3'b010, a}, bad_cmd);
    for (int i = 7; i >= 0; i--) bit_clk(d[i]);
    bit_clk(~^d ^ bad_dat);
    bit_clk(1'b0);
  endtask

  task automatic do_reg0(input logic [3:0] sa, input logic [6:0] d);
    if ((sa == 4'h7) || (sa == 4'h0)) begin
      wr_exp_q.push_back({5'd0, 1'b0, d});
      mem[0] = {1'b0, d};
    end
    send_cmd(sa, {1'b1, d}, 1'b0);
    bit_clk(1'b0);
  endtask

  task automatic do_read(input logic [3:0] sa, input logic [4:0] a, input logic drive);
    logic [8:0] fr;
    fr = {mem[a], ~^mem[a]};
    if (drive) for (int i = 8; i >= 0; i--) rd_exp_q.push_back(fr[i]);
    send_cmd(sa, {3'b011, a}, 1'b0);
    m_sda = 1'b0;
    bit_clk(1'b0);
    for (int i = 0; i < 9; i++) begin
      bus_if.sclk_i = 1'b1;
      wait_clk(8);
      if (drive)
        check("rd_bit", 32'({bus_if.sda_oe, bus_if.sda_o}), 32'({1'b1, rd_exp_q.pop_front()}));
      bus_if.sclk_i = 1'b0;
      wait_clk(10);
    end
    bus_if.sclk_i = 1'b1;
    wait_clk(8);
    check("rd_park", 32'({bus_if.sda_oe, bus_if.sda_o}), drive ? 32'd2 : 32'd0);
    bus_if.sclk_i = 1'b0;
    wait_clk(10);
    check("rd_release", 32'(bus_if.sda_oe), 32'd0);
  endtask

  task automatic dbg_check(input string tag, input logic [4:0] a);
    dbg_addr = a;
    #1;
    check(tag, 32'(dbg_data), 32'(mem[a]));
  endtask

  task automatic end_check(input string tag, input logic oe_allowed);
    check({tag, "_perr"}, 32'(perr_seen), 32'(perr_exp));
    check({tag, "_wr_pending"}, 32'(wr_exp_q.size()), 32'd0);
    if (!oe_allowed) check({tag, "_no_drive"}, 32'(oe_seen), 32'd0);
    oe_seen = 1'b0;
  endtask

  initial begin
    logic [4:0] ra;
    logic [7:0] rd;
    bus_if.sclk_i = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    wait_clk(3);
    check("rst_sda", 32'({bus_if.sda_oe, bus_if.sda_o}), 32'd0);
    check("rst_wr", 32'({reg_wr, parity_err}), 32'd0);
    check("rst_waddr_wdata", 32'({reg_waddr, reg_wdata}), 32'd0);
    dbg_check("rst_dbg5", 5'd5);
    rst_n = 1'b1;
    wait_clk(5);

    do_write(4'h7, 5'd5, 8'hA5, 1'b0, 1'b0);
    dbg_check("wr_dbg5", 5'd5);
    end_check("wr", 1'b0);

    do_read(4'h7, 5'd5, 1'b1);
    end_check("rd", 1'b1);

    do_reg0(4'h0, 7'h2A);
    dbg_check("reg0_dbg0", 5'd0);
    end_check("reg0", 1'b0);

    do_read(4'h0, 5'd0, 1'b0);
    end_check("bcast_rd", 1'b0);

    do_write(4'h3, 5'd5, 8'h11, 1'b0, 1'b0);
    do_read(4'h3, 5'd5, 1'b0);
    dbg_check("sa3_dbg5", 5'd5);
    end_check("sa3", 1'b0);

    do_write(4'h7, 5'd1, 8'h41, 1'b1, 1'b0);
    dbg_check("badcmd_dbg1", 5'd1);
    end_check("badcmd", 1'b0);

    do_write(4'h7, 5'd5, 8'h77, 1'b0, 1'b1);
    dbg_check("baddat_dbg5", 5'd5);
    end_check("baddat", 1'b0);

    ssc();
    for (int i = 0; i < 6; i++) bit_clk((i % 4) != 0);
    do_write(4'h7, 5'd2, 8'h3C, 1'b0, 1'b0);
    dbg_check("abort_dbg2", 5'd2);
    end_check("abort", 1'b0);

    for (int k = 0; k < 4; k++) begin
      ra = 5'($urandom_range(1, 31));
      rd = 8'($urandom_range(0, 255));
      do_write(4'h7, ra, rd, 1'b0, 1'b0);
      do_read(4'h7, ra, 1'b1);
      dbg_check("rand_dbg", ra);
      end_check("rand", 1'b1);
    end

    send_cmd(4'h7, {3'b011, 5'd5}, 1'b0);
    bit_clk(1'b0);
    for (int i = 0; i < 3; i++) begin
      bus_if.sclk_i = 1'b1;
      wait_clk(8);
      bus_if.sclk_i = 1'b0;
      wait_clk(10);
    end
    bus_if.sclk_i = 1'b1;
    wait_clk(8);
    check("pre_rst_oe", 32'(bus_if.sda_oe), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_oe", 32'(bus_if.sda_oe), 32'd0);
    rd_exp_q.delete();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) dbg_check("rst_mid_dbg", 5'(i));
    bus_if.sclk_i = 1'b0;
    m_sda = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    perr_seen = 0;
    perr_exp = 0;
    oe_seen = 1'b0;
    wait_clk(5);

    do_write(4'h7, 5'd9, 8'h5A, 1'b0, 1'b0);
    do_read(4'h7, 5'd9, 1'b1);
    dbg_check("post_rst_dbg9", 5'd9);
    end_check("post_rst", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rffe_slave_responder.md
Name: rffe_slave_responder

Overview:
- MIPI RFFE-style slave responder on the SCLK/SDA two-wire bus.
- It is the far-end counterpart of the controller's serial master, used as an on-board/loopback target and as the bench target for the master path.
- It detects the sequence start, decodes command frames and executes Register-0-Write, Register-Write and Register-Read against an internal 32x8 register file.
- For Register-Read it drives the read data frame back on SDA.

Parameters:
- USID, 4'h7: unique slave ID. SA==0 is broadcast and is accepted for writes only.
- SYNC_STAGES, 2: synchronizer depth on sclk_i/sda_i; must be >=2.

Ports:
- clk  input  1  system clock (48MHz ifclk domain).
- rst_n  input  1  asynchronous active-low reset.
- sclk_i  input  1  bus SCLK from master (asynchronous).
- sda_i  input  1  bus SDA sampled from pad (asynchronous).
- sda_o  output  1  SDA drive value.
- sda_oe  output  1  SDA output enable; the pad is Z when 0.
- reg_wr  output  1  one-cycle pulse when a register is written.
- reg_waddr  output  5  address of the write.
- reg_wdata  output  8  data of the write.
- parity_err  output  1  one-cycle pulse on a command or write-data parity failure.
- dbg_addr  input  5  host-side debug read address.
- dbg_data  output  8  register file content at dbg_addr (combinational).

Behaviour:
- Reset (async, rst_n=0):
  - All FSM state goes to IDLE.
  - sda_o=0, sda_oe=0, reg_wr=0, reg_waddr=0, reg_wdata=0, parity_err=0.
  - Register file is cleared to 0x00.
  - sda_oe drops the moment rst_n asserts, including in the middle of a read.
- Input sync and edge detection:
  - sclk_i and sda_i pass through SYNC_STAGES flops, then one history flop for edge detect.
  - rise/fall are single-cycle strobes. Pin-to-strobe latency is SYNC_STAGES+1 clk.
  - SCLK high and low phases must each be >= 8 clk; slower buses are not supported.
- SSC: synced SDA rises and then falls while synced SCLK stays low throughout.
  - An SSC seen in any state aborts the current sequence.
  - It also forces sda_oe=0 the next cycle and enters CMD with the bit counter cleared.
  - SDA edges while SCLK is high are otherwise ignored.
- Bit sampling: on each SCLK fall strobe, shift the synced SDA, MSB first.
- Parity: odd, taken over all bits of the frame including the parity bit.
- FSM states and transitions:
  - IDLE: wait for SSC.
  - CMD: 13 falls, capturing SA[3:0], C[7:0], P.
    - Parity bad: pulse parity_err, go to IGNORE.
    - SA not equal to USID and not (SA==0 and a write command): go to IGNORE.
    - C[7]=1: Register-0-Write with data C[6:0] zero-extended. Write reg[0], pulse reg_wr, go to BPARK_W.
    - C[7:5]=010: go to WDATA with addr=C[4:0].
    - C[7:5]=011: go to RPARK with addr=C[4:0].
    - Any other opcode: go to IGNORE.
  - WDATA: 9 falls (D[7:0], P).
    - Parity ok: write reg[addr] and pulse reg_wr, with waddr/wdata held until the next write.
    - Parity bad: pulse parity_err and do not write.
    - In both cases go to BPARK_W.
  - BPARK_W: next SCLK fall, then go to IDLE.
  - RPARK: next SCLK fall (master bus park), then go to RDATA and latch the shift register = {reg[addr], odd parity}.
  - RDATA: on each SCLK rise strobe, set sda_oe=1 and sda_o=next bit, MSB first, 9 bits.
  - BPARK_R: on the 10th rise strobe drive sda_o=0. On the following fall strobe clear sda_oe and go to IDLE.
  - IGNORE: stay until the next SSC; never drive SDA.
- Simultaneous events: the register-file write port has priority only over dbg_data. dbg_data reflects new data the cycle after reg_wr.

Test Plan:
- Register-Write: SSC, SA=0x7, C=0x45, P=1, D=0xA5, P=1 → one reg_wr pulse with reg_waddr=5, reg_wdata=0xA5; dbg_addr=5 then reads 0xA5; sda_oe stays 0.
- Register-Read: preload reg[5]=0xA5, send SSC, SA=7, C=0x65, P=0 → after the park cycle, SDA carries 1,0,1,0,0,1,0,1 then parity 1, then 0; sda_oe deasserts on the following fall.
- Register-0-Write and broadcast: SA=0, C=0xAA (P set odd) → reg[0]=0x2A and reg_wr with addr 0. Broadcast read SA=0, C=0x60 → no drive, sda_oe=0 throughout.
- Errors: SA=3 → no reg_wr and no drive. Command with wrong parity → parity_err pulse and no reg_wr. Write with bad data parity → parity_err pulse and register unchanged.
- Abort: SSC inserted after 6 command bits, followed by a full valid write of 0x3C to addr 2 → only that write occurs (reg[2]=0x3C).
- Reset mid-read: drop rst_n during RDATA → sda_oe=0 immediately and all regs read 0. The next valid sequence decodes normally.
